// File: rtl/pll_lock_reset_ctrl_if.sv
// PLL lock/reset handshake: the controller drives the PLL reset and system
// reset; the environment supplies the raw lock pin and the counter clear.
interface pll_lock_reset_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             clear_count;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic [CNT_W-1:0] loss_count;
    logic [1:0]       state;

    // Controller side
    modport master (
        input  pll_locked,
        input  clear_count,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output loss_count,
        output state
    );

    // Environment side: PLL model, status readers
    modport slave (
        output pll_locked,
        output clear_count,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  loss_count,
        input  state
    );
endinterface

// File: rtl/pll_lock_reset_ctrl.sv
// PLL lock qualifier and reset sequencer, clocked from the free-running board
// clock. Pulses the PLL reset, waits for lock (re-arming on timeout), requires
// lock to hold before releasing the system reset, and counts lock losses in RUN.
module pll_lock_reset_ctrl #(
    parameter int unsigned SYNC_STAGES           = 2,
    parameter int unsigned LOCK_STABLE_CYCLES    = 1024,
    parameter int unsigned RELOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned PLL_RST_CYCLES        = 16,
    parameter int unsigned CNT_W                 = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    pll_lock_reset_ctrl_if.master    bus
);

    localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > RELOCK_TIMEOUT_CYCLES)
                                      ? LOCK_STABLE_CYCLES : RELOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   loss_evt;

    // Lock pin synchronizer; lock_s is the oldest stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, shared cycle counter and loss counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_RESET_PLL;
            cnt_q   <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state, counter and loss-count logic; counter clears on every transition
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_d   = loss_q;
        loss_evt = 1'b0;

        unique case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // Lock beats the timeout when both happen on the same cycle
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d  = S_WAIT_LOCK;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // A loss coinciding with a clear is kept
        if (bus.clear_count) begin
            loss_d = loss_evt ? CNT_W'(1) : '0;
        end else if (loss_evt && (loss_q != LOSS_MAX)) begin
            loss_d = loss_q + CNT_W'(1);
        end
    end

    // Moore decodes of the state register
    assign bus.pll_rst    = (state_q == S_RESET_PLL);
    assign bus.sys_rst_n  = (state_q == S_RUN);
    assign bus.ready      = (state_q == S_RUN);
    assign bus.state      = 2'(state_q);
    assign bus.loss_count = loss_q;

endmodule
